// File: rtl/fpu_short_issue.sv
// fpu_short_issue: single-outstanding issue/response stage in front of the short-op FPU
module fpu_short_issue #(
  parameter int TIMEOUT = 63,
  parameter int TAG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_x_i,
  input  logic [31:0]      req_y_i,
  input  logic [4:0]       req_funct5_i,
  input  logic [2:0]       req_rm_i,
  input  logic [TAG_W-1:0] req_rd_i,
  output logic             fpu_en_o,
  output logic [31:0]      fpu_x_o,
  output logic [31:0]      fpu_y_o,
  output logic [4:0]       fpu_funct5_o,
  output logic [2:0]       fpu_rm_o,
  input  logic [31:0]      fpu_res_i,
  input  logic             fpu_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_res_o,
  output logic [TAG_W-1:0] rsp_rd_o,
  output logic             rsp_timeout_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [7:0]  LIMIT     = 8'(TIMEOUT - 1);
  state_e           state_q, state_d;
  logic             en_q, en_d;
  logic [31:0]      x_q, x_d, y_q, y_d, res_q, res_d;
  logic [4:0]       f5_q, f5_d;
  logic [2:0]       rm_q, rm_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic             to_q, to_d, rv_q, rv_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             accept, hit, expire;
  assign accept = state_q == IDLE && req_valid_i;
  assign hit    = state_q == WAIT && fpu_valid_i;
  // The start-pulse cycle is not counted, so a missing result aborts TIMEOUT+1 cycles after fpu_en.
  assign expire = state_q == WAIT && !en_q && cnt_q == LIMIT;
  // Next-state and next-output computation; a result wins over a simultaneous expiry.
  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    x_d     = accept ? req_x_i : x_q;
    y_d     = accept ? req_y_i : y_q;
    f5_d    = accept ? req_funct5_i : f5_q;
    rm_d    = accept ? req_rm_i : rm_q;
    rd_d    = accept ? req_rd_i : rd_q;
    cnt_d   = accept ? 8'd0 : (state_q == WAIT && !en_q && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    res_d   = hit ? fpu_res_i : expire ? CANON_NAN : res_q;
    to_d    = hit ? 1'b0 : expire ? 1'b1 : to_q;
    if (accept) begin
      en_d    = 1'b1;
      state_d = WAIT;
    end
    if (hit || expire) state_d = RESP;
    if (state_q == RESP && rsp_ready_i) state_d = IDLE;
    rv_d = state_d == RESP;
  end
  // State and registered outputs; reset discards any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      f5_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      rv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      x_q     <= x_d;
      y_q     <= y_d;
      f5_q    <= f5_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      to_q    <= to_d;
      rv_q    <= rv_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req_ready_o   = state_q == IDLE;
  assign busy_o        = state_q != IDLE;
  assign fpu_en_o      = en_q;
  assign fpu_x_o       = x_q;
  assign fpu_y_o       = y_q;
  assign fpu_funct5_o  = f5_q;
  assign fpu_rm_o      = rm_q;
  assign rsp_valid_o   = rv_q;
  assign rsp_res_o     = res_q;
  assign rsp_rd_o      = rd_q;
  assign rsp_timeout_o = to_q;
endmodule

// File: tb/tb_fpu_short_issue.sv
// tb_fpu_short_issue: directed and randomized-stream checks of the FPU issue stage
module tb_fpu_short_issue;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid, req_ready;
  logic [31:0] req_x, req_y;
  logic [4:0]  req_funct5;
  logic [2:0]  req_rm;
  logic [4:0]  req_rd;
  logic        fpu_en;
  logic [31:0] fpu_x, fpu_y;
  logic [4:0]  fpu_funct5;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_res;
  logic        fpu_valid;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_res;
  logic [4:0]  rsp_rd;
  logic        rsp_timeout, busy;
  int n_assert = 0;
  int n_fail   = 0;

  fpu_short_issue #(.TIMEOUT(8), .TAG_W(5)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_x_i(req_x), .req_y_i(req_y), .req_funct5_i(req_funct5), .req_rm_i(req_rm), .req_rd_i(req_rd),
    .fpu_en_o(fpu_en), .fpu_x_o(fpu_x), .fpu_y_o(fpu_y), .fpu_funct5_o(fpu_funct5), .fpu_rm_o(fpu_rm),
    .fpu_res_i(fpu_res), .fpu_valid_i(fpu_valid),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_res_o(rsp_res), .rsp_rd_o(rsp_rd),
    .rsp_timeout_o(rsp_timeout), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [4:0] f, input logic [2:0] rm, input logic [4:0] rd);
    req_x = x; req_y = y; req_funct5 = f; req_rm = rm; req_rd = rd;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, ens, lat;
    logic done, exp_to;
    logic [31:0] x, y, r, exp_res;
    logic [4:0] f, rd;
    logic [2:0] rm;
    rst_ni = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_funct5 = '0; req_rm = '0; req_rd = '0;
    fpu_res = '0; fpu_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    chk("rst_ctl", {fpu_en, rsp_valid, rsp_timeout, busy, req_ready}, 5'b00001);
    chk("rst_ops", {fpu_x, fpu_y}, 64'h0);
    chk("rst_rsp", {rsp_res, fpu_funct5, fpu_rm, rsp_rd}, 45'h0);
    tick; tick;
    rst_ni = 1'b1;
    tick;

    // single op, latency 2
    fpu_res = 32'h40400000;
    rsp_ready = 1'b1;
    issue(32'h3F800000, 32'h40000000, 5'd0, 3'd0, 5'd5);
    chk("t1_ops", {fpu_x, fpu_y, fpu_funct5, fpu_rm}, {32'h3F800000, 32'h40000000, 5'd0, 3'd0});
    first = 0; ens = 0;
    for (int k = 1; k <= 6; k++) begin
      ens += int'(fpu_en);
      if (rsp_valid && first == 0) begin
        first = k;
        chk("t1_rsp", {rsp_res, rsp_rd, rsp_timeout}, {32'h40400000, 5'd5, 1'b0});
      end
      fpu_valid = (k == 3);
      tick;
    end
    fpu_valid = 1'b0;
    chk("t1_en_pulses", ens, 1);
    chk("t1_rsp_cycle", first, 4);
    chk("t1_idle", {busy, req_ready}, 2'b01);

    // backpressure, with a second request pending the whole time
    rsp_ready = 1'b0;
    fpu_res = 32'hC0A00000;
    issue(32'h40400000, 32'h40800000, 5'd1, 3'd1, 5'd9);
    tick;
    fpu_valid = 1'b1;
    tick;
    fpu_valid = 1'b0;
    chk("t2_rsp_up", rsp_valid, 1'b1);
    req_x = 32'h11111111; req_y = 32'h22222222; req_funct5 = 5'd2; req_rm = 3'd2; req_rd = 5'd17;
    req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold", {rsp_valid, req_ready, fpu_en, rsp_timeout, rsp_rd, rsp_res}, {1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'hC0A00000});
      tick;
    end
    rsp_ready = 1'b1;
    chk("t2_still_valid", {rsp_valid, req_ready}, 2'b10);
    tick;
    rsp_ready = 1'b0;
    chk("t2_ready_back", {rsp_valid, req_ready, fpu_en}, 3'b010);
    tick;
    req_valid = 1'b0;
    chk("t2_second_accept", {fpu_en, fpu_x, fpu_y, fpu_funct5, fpu_rm}, {1'b1, 32'h11111111, 32'h22222222, 5'd2, 3'd2});

    // timeout on the second request (no fpu_valid)
    for (int j = 0; j < 8; j++) tick;
    chk("t3_not_yet", {rsp_valid, busy}, 2'b01);
    tick;
    chk("t3_timeout", {rsp_valid, rsp_timeout, rsp_rd, rsp_res}, {1'b1, 1'b1, 5'd17, 32'h7FC00000});
    tick;
    fpu_res = 32'h12345678;
    fpu_valid = 1'b1;
    tick;
    fpu_valid = 1'b0;
    chk("t3_late_in_resp", {rsp_valid, rsp_timeout, rsp_res}, {1'b1, 1'b1, 32'h7FC00000});
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    fpu_valid = 1'b1;
    tick;
    fpu_valid = 1'b0;
    chk("t3_late_in_idle", {rsp_valid, busy, fpu_en, rsp_timeout, rsp_res}, {1'b0, 1'b0, 1'b0, 1'b1, 32'h7FC00000});

    // zero-latency FPU
    fpu_res = 32'h3E800000;
    rsp_ready = 1'b1;
    issue(32'h3F000000, 32'h3F000000, 5'd3, 3'd4, 5'd3);
    chk("t4_en", fpu_en, 1'b1);
    fpu_valid = 1'b1;
    tick;
    fpu_valid = 1'b0;
    chk("t4_rsp", {rsp_valid, rsp_timeout, rsp_rd, rsp_res}, {1'b1, 1'b0, 5'd3, 32'h3E800000});
    tick;
    chk("t4_idle", {rsp_valid, busy}, 2'b00);

    // result on the very cycle the watchdog expires: result wins
    fpu_res = 32'hABCDEF01;
    issue(32'h1, 32'h2, 5'd4, 3'd1, 5'd12);
    for (int j = 0; j < 8; j++) tick;
    fpu_valid = 1'b1;
    tick;
    fpu_valid = 1'b0;
    chk("t5_tie", {rsp_valid, rsp_timeout, rsp_rd, rsp_res}, {1'b1, 1'b0, 5'd12, 32'hABCDEF01});
    tick;

    // reset in the middle of WAIT
    rsp_ready = 1'b0;
    issue(32'h55555555, 32'h44444444, 5'd7, 3'd3, 5'd7);
    tick;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_ctl", {fpu_en, rsp_valid, rsp_timeout, busy, req_ready}, 5'b00001);
    chk("t6_rst_data", {fpu_x, fpu_y}, 64'h0);
    chk("t6_rst_rsp", {rsp_res, fpu_funct5, fpu_rm, rsp_rd}, 45'h0);
    tick;
    rst_ni = 1'b1;
    fpu_res = 32'hDEADBEEF;
    fpu_valid = 1'b1;
    tick;
    fpu_valid = 1'b0;
    chk("t6_stray", {rsp_valid, busy, rsp_res}, {1'b0, 1'b0, 32'h0});
    rsp_ready = 1'b1;
    fpu_res = 32'h01020304;
    issue(32'h66666666, 32'h77777777, 5'd8, 3'd2, 5'd8);
    chk("t6_new_accept", {fpu_en, fpu_x}, {1'b1, 32'h66666666});
    fpu_valid = 1'b1;
    tick;
    fpu_valid = 1'b0;
    chk("t6_new_rsp", {rsp_valid, rsp_timeout, rsp_rd, rsp_res}, {1'b1, 1'b0, 5'd8, 32'h01020304});
    tick;
    rsp_ready = 1'b0;

    // random stream against a scoreboard; latency above 8 exceeds the watchdog
    for (int op = 0; op < 20; op++) begin
      x = $urandom; y = $urandom; r = $urandom;
      f = 5'($urandom); rm = 3'($urandom); rd = 5'($urandom);
      lat = $urandom_range(1, 10);
      fpu_res = r;
      exp_res = (lat <= 8) ? r : 32'h7FC00000;
      exp_to = (lat > 8);
      chk("s_ready", req_ready, 1'b1);
      issue(x, y, f, rm, rd);
      done = 1'b0; ens = 0;
      for (int k = 1; k <= 40 && !(done && k > lat + 1); k++) begin
        ens += int'(fpu_en);
        if (busy) chk("s_operands", {fpu_x, fpu_y, fpu_funct5, fpu_rm}, {x, y, f, rm});
        fpu_valid = (k == lat + 1);
        rsp_ready = 1'($urandom_range(0, 1));
        if (rsp_valid && rsp_ready) begin
          chk("s_rsp", {done, rsp_rd, rsp_timeout, rsp_res}, {1'b0, rd, exp_to, exp_res});
          done = 1'b1;
        end
        tick;
      end
      fpu_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("s_done", done, 1'b1);
      chk("s_en", ens, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
